// File: rtl/i2c_pkg.sv
// Shared types for the I2C target engine: FSM state encoding and R/W bit values.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        REG_ADDR,
        REG_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } i2c_state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one raw open-drain line: 2-flop synchroniser, FILT_LEN-sample glitch
// filter, and single-cycle rise/fall flags issued together with the filtered change.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Idle bus is high, so the filtered line starts high to avoid a false edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_target_engine.sv
// I2C target protocol engine: decodes bus events, matches the device address and
// drives byte writes / read data towards the register map behind it.
module i2c_target_engine #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         FILT_LEN = 3,
    parameter int         WR_PULSE = 2,
    parameter int         SDA_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 sda_oe,
    output logic [7:0]           addr,
    output logic [7:0]           wdata,
    output logic                 wr_en_wdata,
    input  logic [7:0]           rdata,
    output logic                 busy,
    output i2c_pkg::i2c_state_t  dbg_state
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_evt, stop_evt;
    logic [7:0] rx_byte;
    logic last_bit;

    i2c_pkg::i2c_state_t state;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       nack;
    logic [7:0] hold_cnt;
    logic       oe_pend;
    logic [7:0] pulse_cnt;
    logic       addr_inc;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (scl_i),
        .level (scl_f),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sda_i),
        .level (sda_f),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_evt = sda_fall & scl_f;
    assign stop_evt  = sda_rise & scl_f;
    assign rx_byte   = {shift[6:0], sda_f};
    assign last_bit  = (bit_cnt == 4'd7);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= i2c_pkg::IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            rw          <= i2c_pkg::RW_WRITE;
            nack        <= 1'b0;
            hold_cnt    <= '0;
            oe_pend     <= 1'b0;
            pulse_cnt   <= '0;
            addr_inc    <= 1'b0;
            sda_oe      <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            wr_en_wdata <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Write strobe runs independently of bus events so it always completes.
            if (wr_en_wdata) begin
                if (pulse_cnt == 8'd1) begin
                    wr_en_wdata <= 1'b0;
                    addr_inc    <= 1'b1;
                end else begin
                    pulse_cnt <= pulse_cnt - 8'd1;
                end
            end
            if (addr_inc) begin
                addr     <= addr + 8'd1;
                addr_inc <= 1'b0;
            end

            if (hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
                if (hold_cnt == 8'd1) sda_oe <= oe_pend;
            end

            if (stop_evt) begin
                state   <= i2c_pkg::IDLE;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (start_evt) begin
                state   <= i2c_pkg::DEV_ADDR;
                bit_cnt <= '0;
            end else if (scl_rise) begin
                case (state)
                    i2c_pkg::DEV_ADDR: if (bit_cnt < 4'd8) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                busy <= 1'b1;
                                rw   <= rx_byte[0];
                            end else begin
                                state <= i2c_pkg::IDLE;
                            end
                        end
                    end
                    i2c_pkg::REG_ADDR: if (bit_cnt < 4'd8) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) addr <= rx_byte;
                    end
                    i2c_pkg::WR_DATA: if (bit_cnt < 4'd8) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            wdata       <= rx_byte;
                            wr_en_wdata <= 1'b1;
                            pulse_cnt   <= 8'(WR_PULSE);
                        end
                    end
                    i2c_pkg::RD_DATA: bit_cnt <= bit_cnt + 4'd1;
                    i2c_pkg::RD_ACK: begin
                        nack <= sda_f;
                        if (!sda_f) addr <= addr + 8'd1;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                // Every SCL fall schedules the next SDA drive value; release unless a state claims the line.
                hold_cnt <= 8'(SDA_HOLD);
                oe_pend  <= 1'b0;
                case (state)
                    i2c_pkg::DEV_ADDR: if (bit_cnt == 4'd8) begin
                        state   <= i2c_pkg::DEV_ACK;
                        oe_pend <= 1'b1;
                    end
                    i2c_pkg::REG_ADDR: if (bit_cnt == 4'd8) begin
                        state   <= i2c_pkg::REG_ACK;
                        oe_pend <= 1'b1;
                    end
                    i2c_pkg::WR_DATA: if (bit_cnt == 4'd8) begin
                        state   <= i2c_pkg::WR_ACK;
                        oe_pend <= 1'b1;
                    end
                    i2c_pkg::DEV_ACK: begin
                        bit_cnt <= '0;
                        if (rw == i2c_pkg::RW_READ) begin
                            state   <= i2c_pkg::RD_DATA;
                            shift   <= rdata;
                            oe_pend <= ~rdata[7];
                        end else begin
                            state <= i2c_pkg::REG_ADDR;
                        end
                    end
                    i2c_pkg::REG_ACK, i2c_pkg::WR_ACK: begin
                        state   <= i2c_pkg::WR_DATA;
                        bit_cnt <= '0;
                    end
                    i2c_pkg::RD_DATA: begin
                        if (bit_cnt == 4'd8) begin
                            state <= i2c_pkg::RD_ACK;
                        end else begin
                            shift   <= {shift[6:0], 1'b0};
                            oe_pend <= ~shift[6];
                        end
                    end
                    i2c_pkg::RD_ACK: begin
                        bit_cnt <= '0;
                        if (nack) begin
                            state <= i2c_pkg::IDLE;
                        end else begin
                            state   <= i2c_pkg::RD_DATA;
                            shift   <= rdata;
                            oe_pend <= ~rdata[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_engine.sv
// Bench for i2c_target_engine: bit-banged I2C master, register-map model and strobe/read scoreboards.
module tb_i2c_target_engine;
    import i2c_pkg::*;

    localparam int Q        = 20;
    localparam int WR_PULSE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    wire        sda_i;
    logic       sda_oe;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wr_en_wdata;
    logic [7:0] rdata;
    logic       busy;
    i2c_state_t dbg_state;

    logic [7:0]  mem [256];
    logic [15:0] exp_q[$];
    logic [7:0]  rd_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    assign sda_i = sda_m & ~sda_oe;
    assign rdata = mem[addr];

    i2c_target_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_i       (scl),
        .sda_i       (sda_i),
        .sda_oe      (sda_oe),
        .addr        (addr),
        .wdata       (wdata),
        .wr_en_wdata (wr_en_wdata),
        .rdata       (rdata),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_bit(input logic b, output logic seen);
        sda_m = b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        seen = sda_i;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic start_cond();
        if (scl == 1'b0) begin
            sda_m = 1'b1;
            wait_clk(Q);
            scl = 1'b1;
            wait_clk(Q);
        end
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) scl_bit(b[i], s);
        scl_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            scl_bit(1'b1, s);
            d[i] = s;
        end
        scl_bit(m_ack, s);
    endtask

    // Strobe monitor: every rising wr_en_wdata pops one expected {addr, wdata}.
    logic        wr_prev = 1'b0;
    int          wr_width = 0;
    logic        wr_stable = 1'b1;
    logic [7:0]  wr_addr_h, wr_data_h;
    logic [15:0] wr_exp;
    always @(negedge clk) begin
        if (wr_en_wdata && !wr_prev) begin
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_exp = exp_q.pop_front();
                check("strobe_addr", 32'(addr), 32'(wr_exp[15:8]));
                check("strobe_wdata", 32'(wdata), 32'(wr_exp[7:0]));
            end
            wr_width  = 1;
            wr_stable = 1'b1;
            wr_addr_h = addr;
            wr_data_h = wdata;
        end else if (wr_en_wdata) begin
            wr_width++;
            if (addr !== wr_addr_h || wdata !== wr_data_h) wr_stable = 1'b0;
        end else if (wr_prev && rst_n) begin
            check("strobe_width", 32'(wr_width), 32'(WR_PULSE));
            check("strobe_stable", 32'(wr_stable), 32'd1);
        end
        wr_prev = wr_en_wdata;
    end

    typedef struct {
        logic [7:0]       dev;
        logic [7:0]       ptr;
        int               n;
        logic [2:0][7:0]  d;
        logic             exp_ack;   // bus level seen in the ACK slot: 0 = ACK
        logic             exp_busy;
        logic [7:0]       exp_addr;
    } wr_vec_t;

    wr_vec_t    vec [4];
    logic       ack;
    logic [7:0] got;
    logic [7:0] a;
    int         lat;
    logic       seen_state;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5B;

        vec[0] = '{dev: 8'h78, ptr: 8'h02, n: 1, d: {8'h00, 8'h00, 8'hA5},
                   exp_ack: 1'b0, exp_busy: 1'b1, exp_addr: 8'h03};
        vec[1] = '{dev: 8'h78, ptr: 8'hFE, n: 3, d: {8'h33, 8'h22, 8'h11},
                   exp_ack: 1'b0, exp_busy: 1'b1, exp_addr: 8'h01};
        vec[2] = '{dev: 8'hA0, ptr: 8'h02, n: 1, d: {8'h00, 8'h00, 8'h55},
                   exp_ack: 1'b1, exp_busy: 1'b0, exp_addr: 8'h01};
        vec[3] = '{dev: 8'h78, ptr: 8'h40, n: 2, d: '0,
                   exp_ack: 1'b0, exp_busy: 1'b1, exp_addr: 8'h42};
        vec[3].d[0] = 8'($urandom_range(0, 255));
        vec[3].d[1] = 8'($urandom_range(0, 255));

        // Reset values
        wait_clk(4);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_wr_en", 32'(wr_en_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        wait_clk(10);

        // Table-driven write transactions
        for (int v = 0; v < 4; v++) begin
            start_cond();
            write_byte(vec[v].dev, ack);
            check($sformatf("v%0d_dev_ack", v), 32'(ack), 32'(vec[v].exp_ack));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'(vec[v].exp_busy));
            write_byte(vec[v].ptr, ack);
            check($sformatf("v%0d_ptr_ack", v), 32'(ack), 32'(vec[v].exp_ack));
            for (int i = 0; i < vec[v].n; i++) begin
                a = vec[v].ptr + 8'(i);
                if (!vec[v].exp_ack) exp_q.push_back({a, vec[v].d[i]});
                write_byte(vec[v].d[i], ack);
                check($sformatf("v%0d_d%0d_ack", v, i), 32'(ack), 32'(vec[v].exp_ack));
            end
            stop_cond();
            check($sformatf("v%0d_final_addr", v), 32'(addr), 32'(vec[v].exp_addr));
            check($sformatf("v%0d_busy_after_stop", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_state_idle", v), 32'(dbg_state), 32'(IDLE));
        end

        // Pointer write, repeated START, read with ACK then NACK
        start_cond();
        write_byte(8'h78, ack);
        check("rd_dev_w_ack", 32'(ack), 32'd0);
        write_byte(8'h01, ack);
        check("rd_ptr_ack", 32'(ack), 32'd0);
        start_cond();
        write_byte(8'h79, ack);
        check("rd_dev_r_ack", 32'(ack), 32'd0);
        rd_q.push_back(mem[8'h01]);
        read_byte(1'b0, got);
        check("rd_byte0", 32'(got), 32'(rd_q.pop_front()));
        rd_q.push_back(mem[8'h02]);
        read_byte(1'b1, got);
        check("rd_byte1", 32'(got), 32'(rd_q.pop_front()));
        check("rd_state_idle_after_nack", 32'(dbg_state), 32'(IDLE));
        check("rd_busy_held", 32'(busy), 32'd1);
        check("rd_addr_after", 32'(addr), 32'h02);
        check("rd_sda_released", 32'(sda_oe), 32'd0);
        stop_cond();
        check("rd_busy_after_stop", 32'(busy), 32'd0);

        // STOP after four data bits: partial byte dropped
        start_cond();
        write_byte(8'h78, ack);
        write_byte(8'h10, ack);
        check("part_ptr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) scl_bit(1'(i), ack);
        stop_cond();
        wait_clk(10);
        check("part_state_idle", 32'(dbg_state), 32'(IDLE));
        check("part_addr", 32'(addr), 32'h10);
        check("part_no_strobe", 32'(wr_en_wdata), 32'd0);

        // One-clock SDA glitch while SCL high must not look like START
        sda_m = 1'b0;
        wait_clk(1);
        sda_m = 1'b1;
        wait_clk(20);
        check("glitch_state_idle", 32'(dbg_state), 32'(IDLE));
        sda_m = 1'b0;
        lat = 0;
        seen_state = 1'b0;
        while (!seen_state && lat < 30) begin
            wait_clk(1);
            lat++;
            if (dbg_state == DEV_ADDR) seen_state = 1'b1;
        end
        check("start_detected", 32'(seen_state), 32'd1);
        check("start_latency_in_range", 32'(lat >= 5 && lat <= 6), 32'd1);
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
        stop_cond();

        // Reset during the address ACK
        start_cond();
        for (int i = 7; i >= 1; i--) begin
            a = 8'h78;
            scl_bit(a[i], ack);
        end
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        scl = 1'b0;
        wait_clk(6);
        check("hold_oe_not_yet", 32'(sda_oe), 32'd0);
        wait_clk(8);
        check("ack_oe_driven", 32'(sda_oe), 32'd1);
        check("ack_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_sda_oe", 32'(sda_oe), 32'd0);
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_wdata", 32'(wdata), 32'd0);
        check("midrst_wr_en", 32'(wr_en_wdata), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        wait_clk(2);
        scl = 1'b1;
        sda_m = 1'b1;
        rst_n = 1'b1;
        wait_clk(20);

        check("strobe_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
